// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with per-byte write enables, selectable read latency,
// selectable read-during-write result and an optional post-reset clear sequencer.
module sram_dp_be #(
  parameter int N_WIDTH    = 32,
  parameter int N_ADDR     = 10,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [N_ADDR-1:0]    wr_addr,
  input  logic [N_WIDTH/8-1:0] wr_be,
  input  logic [N_WIDTH-1:0]   wr_data,
  input  logic                 rd_en,
  input  logic [N_ADDR-1:0]    rd_addr,
  output logic [N_WIDTH-1:0]   rd_data,
  output logic                 rd_valid,
  output logic                 init_busy
);

  localparam int BE_W  = N_WIDTH / 8;
  localparam int DEPTH = 2 ** N_ADDR;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $fatal(1, "sram_dp_be: RD_LAT must be 1 or 2");
  end
  if (N_WIDTH % 8 != 0) begin : g_bad_width
    $fatal(1, "sram_dp_be: N_WIDTH must be a multiple of 8");
  end

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [N_ADDR-1:0]   clr_cnt_q, clr_cnt_d;
  logic [N_WIDTH-1:0]  mem_q [DEPTH];
  logic [N_WIDTH-1:0]  rd_word;
  logic                usr_we, usr_re, clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + N_ADDR'(1);
        if (clr_cnt_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // User requests are only honoured once the clear has finished.
  assign usr_we    = (state_q == S_IDLE) && wr_en;
  assign usr_re    = (state_q == S_IDLE) && rd_en;
  assign init_busy = (state_q == S_CLEAR);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (usr_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Same-address bypass: new-data mode forwards the enabled write lanes.
  always_comb begin
    rd_word = mem_q[rd_addr];
    if (RDW_MODE == 1 && usr_we && (wr_addr == rd_addr)) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Stage p1: array read register
  logic [N_WIDTH-1:0] rd_p1_q;
  logic               vld_p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1_q  <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= usr_re;
      if (usr_re) rd_p1_q <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    // Stage p2: optional output register
    logic [N_WIDTH-1:0] rd_p2_q;
    logic               vld_p2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_p2_q  <= '0;
        vld_p2_q <= 1'b0;
      end else begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) rd_p2_q <= rd_p1_q;
      end
    end

    assign rd_data  = rd_p2_q;
    assign rd_valid = vld_p2_q;
  end else begin : g_lat1
    assign rd_data  = rd_p1_q;
    assign rd_valid = vld_p1_q;
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: two instances (latency 1 / old-data, latency 2 / new-data)
// share one stimulus stream and are compared every cycle against a memory model.
module tb_sram_dp_be;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [3:0]    wr_be = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, busy_a, busy_b;

  int errs = 0;
  int checks = 0;

  logic [31:0] mm [DEPTH];
  int          busy_left = 0;
  logic        a_vld = 1'b0, b_vld = 1'b0, p_vld = 1'b0;
  logic [31:0] a_dat = '0, b_dat = '0, p_dat = '0;

  always #5 clk = ~clk;

  sram_dp_be #(.N_WIDTH(32), .N_ADDR(AW), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(busy_a));

  sram_dp_be #(.N_WIDTH(32), .N_ADDR(AW), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(busy_b));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the model applies the same edge the DUTs see, then outputs are compared.
  task automatic cycle();
    logic [31:0] old, res_new;
    logic        acc_rd, acc_wr;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      busy_left = DEPTH;
      a_vld = 1'b0; a_dat = '0;
      b_vld = 1'b0; b_dat = '0;
      p_vld = 1'b0;
    end else begin
      acc_rd = (busy_left == 0) && rd_en;
      acc_wr = (busy_left == 0) && wr_en;
      if (busy_left > 0) busy_left--;
      old     = mm[rd_addr];
      res_new = (acc_wr && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old;
      b_vld = p_vld;
      if (p_vld) b_dat = p_dat;
      p_vld = acc_rd;
      if (acc_rd) p_dat = res_new;
      a_vld = acc_rd;
      if (acc_rd) a_dat = old;
      if (acc_wr) mm[wr_addr] = merge(mm[wr_addr], wr_data, wr_be);
    end
    @(negedge clk);
    chk("busy_a",  busy_a,     busy_left > 0);
    chk("busy_b",  busy_b,     busy_left > 0);
    chk("valid_a", rd_valid_a, a_vld);
    chk("valid_b", rd_valid_b, b_vld);
    chk("data_a",  rd_data_a,  a_dat);
    chk("data_b",  rd_data_b,  b_dat);
  endtask

  initial begin
    int n, va, vb, fa, fb, la, lb;

    // Reset and clear, with a write and read attempted during the clear
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_valid_b", rd_valid_b, 1'b0);
    chk("rst_data_a", rd_data_a, 32'h0);
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd3;
    n = 0; va = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      cycle();
      va += int'(rd_valid_a) + int'(rd_valid_b);
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
    chk("clear_len", n, 16);
    chk("clear_no_valid", va, 0);

    va = 0; vb = 0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_en = 1'b1; rd_addr = AW'(k);
      cycle();
      va += int'(rd_valid_a); vb += int'(rd_valid_b);
    end
    rd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      va += int'(rd_valid_a); vb += int'(rd_valid_b);
    end
    chk("clear_reads_a", va, 16);
    chk("clear_reads_b", vb, 16);
    rd_en = 1'b1; rd_addr = 4'd3;
    cycle();
    rd_en = 1'b0;
    cycle();
    chk("clr_addr3_a", rd_data_a, 32'h0);
    chk("clr_addr3_b", rd_data_b, 32'h0);

    // Byte enables
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1122_3344; wr_be = 4'hF;
    cycle();
    wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
    cycle();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd5;
    cycle();
    rd_en = 1'b0;
    cycle();
    cycle();
    chk("be_a", rd_data_a, 32'h11BB_33DD);
    chk("be_b", rd_data_b, 32'h11BB_33DD);

    // Streaming reads
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = k * 32'h0101_0101; wr_be = 4'hF;
      cycle();
    end
    wr_en = 1'b0;
    va = 0; vb = 0; fa = -1; fb = -1; la = -1; lb = -1;
    for (int i = 0; i < 11; i++) begin
      rd_en = (i < 8); rd_addr = AW'(i);
      cycle();
      if (rd_valid_a) begin va++; la = i; if (fa < 0) fa = i; end
      if (rd_valid_b) begin vb++; lb = i; if (fb < 0) fb = i; end
    end
    rd_en = 1'b0;
    chk("stream_first_a", fa, 0);
    chk("stream_first_b", fb, 1);
    chk("stream_cnt_a", va, 8);
    chk("stream_cnt_b", vb, 8);
    chk("stream_span_a", la - fa + 1, 8);
    chk("stream_span_b", lb - fb + 1, 8);
    chk("stream_hold_a", rd_data_a, 32'h0707_0707);
    chk("stream_hold_b", rd_data_b, 32'h0707_0707);

    // Read-during-write to the same address
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
    cycle();
    wr_data = 32'h1234_5678; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 4'd9;
    cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_old_a", rd_data_a, 32'hDEAD_BEEF);
    cycle();
    chk("rdw_new_b", rd_data_b, 32'hDEAD_5678);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    cycle();
    chk("rdw_next_a", rd_data_a, 32'hDEAD_5678);
    chk("rdw_next_b", rd_data_b, 32'hDEAD_5678);

    // Random traffic on a narrow address window to force collisions
    for (int i = 0; i < 300; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 3));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 3));
      cycle();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    cycle();
    cycle();

    // Reset while the clear counter is at 7
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk("midclr_busy", busy_b, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    chk("midclr_len", n, 16);

    // Reset with a read in flight
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
    cycle();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd5;
    cycle();
    rd_en = 1'b0;
    rst = 1'b1;
    cycle();
    chk("flight_valid_a", rd_valid_a, 1'b0);
    chk("flight_valid_b", rd_valid_b, 1'b0);
    chk("flight_data_a", rd_data_a, 32'h0);
    chk("flight_data_b", rd_data_b, 32'h0);
    rst = 1'b0;
    va = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      va += int'(rd_valid_a) + int'(rd_valid_b);
    end
    chk("flight_late_valid", va, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
